// File: rtl/pattern_serializer_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state encodings and counter width.
package pattern_serializer_pkg;

  localparam int unsigned COUNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_GAP    = 2'd3
  } state_t;

endpackage

// File: rtl/pattern_serializer_counter.sv
// Loadable down counter with a terminal-count flag; holds at zero.
module pattern_serializer_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] count;

  // Load takes priority over decrement; count never wraps below zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/pattern_serializer.sv
// Serial bit-pattern transmitter: accepts a parallel word on valid/ready and
// shifts it out MSB-first with a qualifying o_valid.
// Optional feature: define SERIAL_PARITY_EN to append an even-parity bit to each frame.
module pattern_serializer
  import pattern_serializer_pkg::*;
#(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             o,
  output logic             o_valid,
  output logic             busy
);

  localparam int unsigned BIT_W    = (WIDTH > 256) ? $clog2(WIDTH) : COUNT_W;
  localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;
  localparam bit          HAS_GAP  = (GAP_CYCLES > 0);

  state_t           state;
  // The MSB goes straight to o on accept, so only the remaining bits are held.
  logic [WIDTH-2:0] rest;
  logic             accept;
  logic             bit_tc;
  logic             gap_load;
  logic             gap_tc;
`ifdef SERIAL_PARITY_EN
  logic             par_q;
`endif

  assign data_ready = (state == S_IDLE) && !reset;
  assign busy       = (state != S_IDLE);
  assign accept     = data_valid && data_ready;

  // Gap counter is armed on the edge that enters GAP.
  always_comb begin
    gap_load = 1'b0;
`ifdef SERIAL_PARITY_EN
    if (HAS_GAP && (state == S_PARITY)) gap_load = 1'b1;
`else
    if (HAS_GAP && (state == S_SHIFT) && bit_tc) gap_load = 1'b1;
`endif
  end

  pattern_serializer_counter #(.W(BIT_W)) u_bit_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (accept),
    .load_val (BIT_W'(WIDTH - 1)),
    .en       (state == S_SHIFT),
    .tc       (bit_tc)
  );

  pattern_serializer_counter #(.W(COUNT_W)) u_gap_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (gap_load),
    .load_val (COUNT_W'(GAP_LOAD)),
    .en       (state == S_GAP),
    .tc       (gap_tc)
  );

  // Frame sequencer with registered serial outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      rest    <= '0;
      o       <= 1'b0;
      o_valid <= 1'b0;
`ifdef SERIAL_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          o       <= 1'b0;
          o_valid <= 1'b0;
          if (accept) begin
            state   <= S_SHIFT;
            rest    <= data_in[WIDTH-2:0];
            o       <= data_in[WIDTH-1];
            o_valid <= 1'b1;
`ifdef SERIAL_PARITY_EN
            par_q   <= ^data_in;
`endif
          end
        end
        S_SHIFT: begin
          if (bit_tc) begin
            rest <= '0;
`ifdef SERIAL_PARITY_EN
            state   <= S_PARITY;
            o       <= par_q;
            o_valid <= 1'b1;
`else
            state   <= HAS_GAP ? S_GAP : S_IDLE;
            o       <= 1'b0;
            o_valid <= 1'b0;
`endif
          end else begin
            o       <= rest[WIDTH-2];
            o_valid <= 1'b1;
            rest    <= rest << 1;
          end
        end
`ifdef SERIAL_PARITY_EN
        S_PARITY: begin
          state   <= HAS_GAP ? S_GAP : S_IDLE;
          o       <= 1'b0;
          o_valid <= 1'b0;
        end
`endif
        S_GAP: begin
          o       <= 1'b0;
          o_valid <= 1'b0;
          if (gap_tc) state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          o       <= 1'b0;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Bench for pattern_serializer: directed plus random words checked against a frame model.
module tb_pattern_serializer;

  localparam int unsigned W = 10;
`ifdef SERIAL_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = W + PAR;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         data_ready, o, o_valid, busy;
  logic [W-1:0] g_data_in;
  logic         g_data_valid;
  logic         g_data_ready, g_o, g_o_valid, g_busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pattern_serializer #(.WIDTH(W), .GAP_CYCLES(0)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .o(o), .o_valid(o_valid), .busy(busy)
  );

  pattern_serializer #(.WIDTH(W), .GAP_CYCLES(3)) dut_gap (
    .clock(clock), .reset(reset), .data_in(g_data_in), .data_valid(g_data_valid),
    .data_ready(g_data_ready), .o(g_o), .o_valid(g_o_valid), .busy(g_busy)
  );

  // Frame model: bits MSB-first, then optional even parity over the word.
  function automatic logic exp_bit(input logic [W-1:0] w, input int j);
    int ones;
    if (j < int'(W)) return logic'((w >> (int'(W) - 1 - j)) & 1);
    ones = 0;
    for (int k = 0; k < int'(W); k++) ones += int'((w >> k) & 1);
    return logic'(ones % 2);
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called at the negedge where the first bit is visible. mode: 0 release valid, 1 hold valid, 2 scramble inputs.
  task automatic check_frame(input logic [W-1:0] w, input int mode);
    for (int j = 0; j < FL; j++) begin
      chk("bit_valid", o_valid, 1'b1);
      chk($sformatf("bit%0d", j), o, exp_bit(w, j));
      chk("ready_low_in_frame", data_ready, 1'b0);
      chk("busy_in_frame", busy, 1'b1);
      if (mode == 2) begin
        data_in    = W'($urandom);
        data_valid = logic'($urandom_range(0, 1));
      end
      if ((j == FL - 1) && (mode != 1)) data_valid = 1'b0;
      @(negedge clock);
    end
    chk("frame_end_valid", o_valid, 1'b0);
    chk("idle_ready", data_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);
  endtask

  task automatic send(input logic [W-1:0] w, input int mode, input logic [W-1:0] next_w);
    chk("ready_before_send", data_ready, 1'b1);
    data_in    = w;
    data_valid = 1'b1;
    @(negedge clock);
    data_in = next_w;
    if (mode == 0) data_valid = 1'b0;
    check_frame(w, mode);
  endtask

  task automatic send_gap(input logic [W-1:0] w);
    chk("gap_ready_before", g_data_ready, 1'b1);
    g_data_in    = w;
    g_data_valid = 1'b1;
    @(negedge clock);
    g_data_valid = 1'b0;
    for (int j = 0; j < FL; j++) begin
      chk("gap_dut_valid", g_o_valid, 1'b1);
      chk($sformatf("gap_dut_bit%0d", j), g_o, exp_bit(w, j));
      @(negedge clock);
    end
    for (int c = 0; c < 3; c++) begin
      chk("gap_valid_low", g_o_valid, 1'b0);
      chk("gap_o_low", g_o, 1'b0);
      chk("gap_busy", g_busy, 1'b1);
      chk("gap_ready_low", g_data_ready, 1'b0);
      @(negedge clock);
    end
    chk("gap_done_ready", g_data_ready, 1'b1);
    chk("gap_done_busy", g_busy, 1'b0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    reset        = 1'b1;
    data_in      = '0;
    data_valid   = 1'b0;
    g_data_in    = '0;
    g_data_valid = 1'b0;

    // Reset held for three cycles.
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("rst_o", o, 1'b0);
      chk("rst_o_valid", o_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", data_ready, 1'b0);
    end
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_ready", data_ready, 1'b1);
    chk("post_rst_o_valid", o_valid, 1'b0);

    // Directed words.
    send(10'b1110011001, 0, '0);
    send(10'b1000000000, 0, '0);

    // Back-to-back with valid held high.
    a = W'($urandom);
    b = W'($urandom);
    send(a, 1, b);
    @(negedge clock);
    check_frame(b, 0);

    // Inputs scrambled during the frame.
    send(W'($urandom), 2, '0);

    // Reset after the fourth bit.
    a = W'($urandom);
    data_in    = a;
    data_valid = 1'b1;
    @(negedge clock);
    data_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("pre_abort_valid", o_valid, 1'b1);
      chk($sformatf("pre_abort_bit%0d", j), o, exp_bit(a, j));
      @(negedge clock);
    end
    reset = 1'b1;
    @(negedge clock);
    chk("abort_o_valid", o_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", data_ready, 1'b0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("no_resume_valid", o_valid, 1'b0);
      @(negedge clock);
    end
    send(W'($urandom), 0, '0);

    // Reset and valid together: nothing captured.
    reset      = 1'b1;
    data_valid = 1'b1;
    data_in    = W'($urandom);
    @(negedge clock);
    reset      = 1'b0;
    data_valid = 1'b0;
    chk("rst_vs_valid_busy", busy, 1'b0);
    chk("rst_vs_valid_o_valid", o_valid, 1'b0);
    @(negedge clock);
    chk("rst_vs_valid_busy2", busy, 1'b0);

    // Random words, mixed modes.
    for (int n = 0; n < 6; n++) begin
      send(W'($urandom), (n % 3 == 1) ? 2 : 0, '0);
    end

    // Gap instance.
    send_gap(10'b1110011001);
    send_gap(W'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
